// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and types for the MIPS pipeline slice.
//   XLEN / RAW     : data width and register-address width
//   LT_*           : load_type encodings driven by the MEM stage
//   wb_reg_t       : contents of the MEM/WB pipeline register
package mips_pkg;

    localparam int XLEN = 32;
    localparam int RAW  = 5;

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;

    typedef struct packed {
        logic            wb_valid;
        logic            regwrite;
        logic            memtoreg;
        logic [2:0]      load_type;
        logic [RAW-1:0]  wa;
        logic [XLEN-1:0] alu_result;
    } wb_reg_t;

endpackage

// File: rtl/load_extend.sv
// load_extend: combinational little-endian load alignment and extension.
//   load_type : LT_* encoding (reserved codes behave as LW)
//   off       : byte offset within the word (address bits [1:0])
//   rdata     : raw 32-bit word from data memory
//   ext_data  : aligned, sign/zero-extended result
//   misalign  : access is not naturally aligned for its size
module load_extend
    import mips_pkg::*;
(
    input  logic [2:0]      load_type,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] ext_data,
    output logic            misalign
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte lane.
    always_comb begin
        byte_s = 8'h00;
        case (off)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
    end

    // Select the addressed halfword lane; off[0] only matters for misalignment.
    always_comb begin
        half_s = 16'h0000;
        if (off[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extend the selected lane and flag unnatural alignment.
    always_comb begin
        ext_data = rdata;
        misalign = 1'b0;
        case (load_type)
            LT_LB: begin
                ext_data = {{24{byte_s[7]}}, byte_s};
                misalign = 1'b0;
            end
            LT_LBU: begin
                ext_data = {24'h000000, byte_s};
                misalign = 1'b0;
            end
            LT_LH: begin
                ext_data = {{16{half_s[15]}}, half_s};
                misalign = off[0];
            end
            LT_LHU: begin
                ext_data = {16'h0000, half_s};
                misalign = off[0];
            end
            LT_LW: begin
                ext_data = rdata;
                misalign = (off != 2'd0);
            end
            default: begin
                // Reserved encodings are treated as a full-word load.
                ext_data = rdata;
                misalign = (off != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the 5-stage MIPS pipeline.
//   clk, rst_n          : clock, synchronous active-low reset
//   m_*                 : MEM-stage instruction captured into the WB register
//   dmem_rdata          : raw load word, valid while the load sits in WB
//   we3/wa3/wd3         : regfile write port
//   ra1/ra2, rf_rd1/2   : ID-stage read addresses and raw regfile data
//   byp_rd1/2           : read data with same-cycle WB write bypassed in
//   instret             : retired-instruction counter (wraps)
//   exc_misalign/addr   : sticky misaligned-load flag and first address
//   exc_clr             : clears the sticky exception state
module wb_stage
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m_valid,
    input  logic            m_regwrite,
    input  logic            m_memtoreg,
    input  logic [2:0]      m_load_type,
    input  logic [RAW-1:0]  m_wa,
    input  logic [XLEN-1:0] m_alu_result,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            we3,
    output logic [RAW-1:0]  wa3,
    output logic [XLEN-1:0] wd3,
    input  logic [RAW-1:0]  ra1,
    input  logic [RAW-1:0]  ra2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    output logic [XLEN-1:0] byp_rd1,
    output logic [XLEN-1:0] byp_rd2,
    output logic [XLEN-1:0] instret,
    output logic            exc_misalign,
    output logic [XLEN-1:0] exc_addr,
    input  logic            exc_clr
);

    wb_reg_t         wb_r;
    logic [XLEN-1:0] ext_data_s;
    logic            lx_misalign_s;
    logic            misalign_s;

    load_extend u_load_extend (
        .load_type (wb_r.load_type),
        .off       (wb_r.alu_result[1:0]),
        .rdata     (dmem_rdata),
        .ext_data  (ext_data_s),
        .misalign  (lx_misalign_s)
    );

    // MEM/WB pipeline register; no stall path, flush arrives as m_valid=0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_r <= '0;
        end else begin
            wb_r.wb_valid   <= m_valid;
            wb_r.regwrite   <= m_regwrite;
            wb_r.memtoreg   <= m_memtoreg;
            wb_r.load_type  <= m_load_type;
            wb_r.wa         <= m_wa;
            wb_r.alu_result <= m_alu_result;
        end
    end

    // Regfile write port. rst_n gates we3 so an instruction caught in WB by
    // a reset is dropped rather than committed at the resetting edge.
    always_comb begin
        misalign_s = wb_r.memtoreg & lx_misalign_s;
        wa3        = wb_r.wa;
        if (wb_r.memtoreg) begin
            wd3 = ext_data_s;
        end else begin
            wd3 = wb_r.alu_result;
        end
        we3 = rst_n & wb_r.wb_valid & wb_r.regwrite
            & (wb_r.wa != 5'd0) & ~misalign_s;
    end

    // Same-cycle bypass: the regfile commits at the edge, after ID reads it.
    always_comb begin
        if (we3 && (wa3 == ra1) && (ra1 != 5'd0)) begin
            byp_rd1 = wd3;
        end else begin
            byp_rd1 = rf_rd1;
        end
        if (we3 && (wa3 == ra2) && (ra2 != 5'd0)) begin
            byp_rd2 = wd3;
        end else begin
            byp_rd2 = rf_rd2;
        end
    end

    // Retired-instruction counter; misaligned loads still retire.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret <= 32'h0000_0000;
        end else if (wb_r.wb_valid) begin
            instret <= instret + 32'h0000_0001;
        end else begin
            instret <= instret;
        end
    end

    // Sticky misalignment capture; clear wins over a same-cycle capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exc_misalign <= 1'b0;
            exc_addr     <= 32'h0000_0000;
        end else if (exc_clr) begin
            exc_misalign <= 1'b0;
            exc_addr     <= 32'h0000_0000;
        end else if (wb_r.wb_valid && misalign_s && !exc_misalign) begin
            exc_misalign <= 1'b1;
            exc_addr     <= wb_r.alu_result;
        end else begin
            exc_misalign <= exc_misalign;
            exc_addr     <= exc_addr;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_valid = 1'b0, m_regwrite = 1'b0, m_memtoreg = 1'b0;
    logic [2:0]  m_load_type = 3'd0;
    logic [4:0]  m_wa = 5'd0;
    logic [31:0] m_alu_result = 32'd0, dmem_rdata = 32'd0;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [4:0]  ra1 = 5'd0, ra2 = 5'd0;
    logic [31:0] rf_rd1 = 32'd0, rf_rd2 = 32'd0, byp_rd1, byp_rd2, instret, exc_addr;
    logic        exc_misalign, exc_clr = 1'b0;

    wb_stage dut (
        .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_regwrite(m_regwrite),
        .m_memtoreg(m_memtoreg), .m_load_type(m_load_type), .m_wa(m_wa),
        .m_alu_result(m_alu_result), .dmem_rdata(dmem_rdata), .we3(we3), .wa3(wa3),
        .wd3(wd3), .ra1(ra1), .ra2(ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .byp_rd1(byp_rd1), .byp_rd2(byp_rd2), .instret(instret),
        .exc_misalign(exc_misalign), .exc_addr(exc_addr), .exc_clr(exc_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v, rw, mtr;
        bit [2:0]    lt;
        bit [4:0]    wa;
        bit [31:0]   alu;
    } txn_t;

    typedef struct {
        bit          we;
        bit [4:0]    wa;
        bit [31:0]   wd, b1, b2, cnt;
        bit          exc;
        bit [31:0]   addr;
    } exp_t;

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_pass = 0;
    bit    drv_done = 0;

    // Reference model state: the instruction now in WB and architectural state.
    txn_t  wb_m = '{default: 0};
    bit [31:0] cnt_m = 32'd0, addr_m = 32'd0;
    bit    exc_m = 1'b0;

    function automatic int access_size(input bit [2:0] lt);
        if (lt == LT_LB || lt == LT_LBU) return 1;
        if (lt == LT_LH || lt == LT_LHU) return 2;
        return 4;
    endfunction

    function automatic bit is_misaligned(input txn_t t);
        return t.mtr && ((t.alu % access_size(t.lt)) != 0);
    endfunction

    function automatic bit [31:0] load_value(input bit [2:0] lt, input bit [31:0] addr,
                                             input bit [31:0] word);
        bit [31:0] b, h;
        b = (word >> (8 * (addr % 4))) & 32'hFF;
        h = (word >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (lt)
            LT_LB:   return (b >= 32'd128) ? b - 32'd256 : b;
            LT_LBU:  return b;
            LT_LH:   return (h >= 32'd32768) ? h - 32'd65536 : h;
            LT_LHU:  return h;
            default: return word;
        endcase
    endfunction

    task automatic check(input string name, input bit [31:0] act, input bit [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    endtask

    // One cycle: present nxt on m_*, and side inputs for the instruction in WB.
    task automatic cyc(input txn_t nxt, input bit [31:0] rdata,
                       input bit [4:0] a1, input bit [4:0] a2,
                       input bit [31:0] r1, input bit [31:0] r2,
                       input bit rst, input bit clr, input bit frc);
        exp_t e;
        bit   mis;
        @(negedge clk);
        m_valid = nxt.v; m_regwrite = nxt.rw; m_memtoreg = nxt.mtr;
        m_load_type = nxt.lt; m_wa = nxt.wa; m_alu_result = nxt.alu;
        dmem_rdata = rdata; ra1 = a1; ra2 = a2; rf_rd1 = r1; rf_rd2 = r2;
        rst_n = !rst; exc_clr = clr;
        mis  = is_misaligned(wb_m);
        e.wa = wb_m.wa;
        e.wd = wb_m.mtr ? load_value(wb_m.lt, wb_m.alu, rdata) : wb_m.alu;
        e.we = !rst && wb_m.v && wb_m.rw && (wb_m.wa != 0) && !mis;
        e.b1 = (e.we && a1 == wb_m.wa && a1 != 0) ? e.wd : r1;
        e.b2 = (e.we && a2 == wb_m.wa && a2 != 0) ? e.wd : r2;
        e.cnt = cnt_m; e.exc = exc_m; e.addr = addr_m;
        sb.push_back(e);
        if (frc) begin
            #2 force dut.instret = 32'hFFFF_FFFF;
            #1 release dut.instret;
            cnt_m = 32'hFFFF_FFFF;
        end
        if (rst) begin
            wb_m = '{default: 0}; cnt_m = 0; exc_m = 0; addr_m = 0;
        end else begin
            if (wb_m.v) cnt_m = cnt_m + 32'd1;
            if (clr) begin
                exc_m = 0; addr_m = 0;
            end else if (wb_m.v && mis && !exc_m) begin
                exc_m = 1; addr_m = wb_m.alu;
            end
            wb_m = nxt;
        end
    endtask

    function automatic txn_t mk(input bit v, input bit rw, input bit mtr, input bit [2:0] lt,
                                input bit [4:0] wa, input bit [31:0] alu);
        txn_t t;
        t.v = v; t.rw = rw; t.mtr = mtr; t.lt = lt; t.wa = wa; t.alu = alu;
        return t;
    endfunction

    // Monitor: compare the DUT against the oldest expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("we3", {31'd0, we3}, {31'd0, e.we});
                if (e.we) begin
                    check("wa3", {27'd0, wa3}, {27'd0, e.wa});
                    check("wd3", wd3, e.wd);
                end
                check("byp_rd1", byp_rd1, e.b1);
                check("byp_rd2", byp_rd2, e.b2);
                check("instret", instret, e.cnt);
                check("exc_misalign", {31'd0, exc_misalign}, {31'd0, e.exc});
                check("exc_addr", exc_addr, e.addr);
            end
        end
    end

    // Stimulus: directed test-plan sequence followed by random traffic.
    initial begin
        txn_t bub, t;
        bit [31:0] w;
        bub = mk(0, 0, 0, 3'd0, 5'd0, 32'd0);
        w = 32'h80FF7F01;
        cyc(bub, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(bub, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(mk(1, 1, 0, LT_LW, 5'd5, 32'h12345678), 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(mk(1, 1, 1, LT_LB, 5'd1, 32'h00000101), 0, 5, 0, 32'h11, 0, 0, 0, 0);
        cyc(mk(1, 1, 1, LT_LBU, 5'd2, 32'h00000103), w, 1, 0, 0, 0, 0, 0, 0);
        cyc(mk(1, 1, 1, LT_LH, 5'd3, 32'h00000102), w, 2, 0, 0, 0, 0, 0, 0);
        cyc(mk(1, 1, 1, LT_LHU, 5'd4, 32'h00000100), w, 3, 0, 0, 0, 0, 0, 0);
        cyc(mk(1, 1, 1, LT_LW, 5'd6, 32'h00000100), w, 4, 0, 0, 0, 0, 0, 0);
        cyc(mk(1, 1, 0, LT_LW, 5'd7, 32'hCAFE0000), w, 6, 0, 0, 0, 0, 0, 0);
        cyc(mk(1, 1, 0, LT_LW, 5'd0, 32'hDEADBEEF), 0, 7, 0, 0, 0, 0, 0, 0);
        cyc(mk(1, 1, 1, LT_LW, 5'd8, 32'h00001002), 0, 0, 0, 0, 32'h55, 0, 0, 0);
        cyc(mk(1, 1, 1, LT_LH, 5'd9, 32'h00002001), w, 8, 0, 0, 0, 0, 0, 0);
        cyc(bub, w, 9, 0, 0, 0, 0, 0, 0);
        cyc(bub, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(bub, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(mk(1, 1, 0, LT_LW, 5'd10, 32'h0BADF00D), 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(bub, 0, 10, 0, 0, 0, 1, 0, 0);
        cyc(bub, 0, 10, 0, 0, 0, 0, 0, 0);
        cyc(bub, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(mk(1, 1, 0, LT_LW, 5'd11, 32'h00000011), 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(bub, 0, 11, 0, 0, 0, 0, 0, 0);
        cyc(bub, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            t = mk($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                   3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom);
            cyc(t, $urandom, ($urandom_range(0, 1) != 0) ? wb_m.wa : 5'($urandom),
                5'($urandom), $urandom, $urandom, $urandom_range(0, 99) == 0,
                $urandom_range(0, 15) == 0, 0);
        end
        cyc(bub, 0, 0, 0, 0, 0, 0, 0, 0);
        drv_done = 1;
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        #3;
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
